// File: rtl/ucsbece154b_perf_counters_if.sv
// Bus bundle between the core taps and the performance-counter block.
// master: the side that drives the event taps and the readout select.
// slave:  the counter block itself.
interface ucsbece154b_perf_counters_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 ReadEnable_i;
  logic                 Ready_i;
  logic                 MemReadRequest_i;
  logic                 BranchE_i;
  logic                 JumpE_i;
  logic                 MispredictE_i;
  logic                 Clear_i;
  logic                 Freeze_i;
  logic [3:0]           CntSel_i;
  logic [CNT_WIDTH-1:0] CntValue_o;
  logic [8:0]           Overflow_o;

  modport master (
    output ReadEnable_i, Ready_i, MemReadRequest_i,
    output BranchE_i, JumpE_i, MispredictE_i,
    output Clear_i, Freeze_i, CntSel_i,
    input  CntValue_o, Overflow_o
  );

  modport slave (
    input  ReadEnable_i, Ready_i, MemReadRequest_i,
    input  BranchE_i, JumpE_i, MispredictE_i,
    input  Clear_i, Freeze_i, CntSel_i,
    output CntValue_o, Overflow_o
  );
endinterface

// File: rtl/ucsbece154b_perf_counters.sv
// Performance counters for the pipelined core with icache.
// Counter map: 0 FETCH, 1 HIT, 2 MISS, 3 STALL, 4 BRANCH, 5 BRANCH_OK,
//              6 JUMP, 7 JUMP_OK, 8 CYCLE. Select 9..15 reads 0.
//
// Fetch FSM
//   state  | meaning
//   IDLE   | no refill outstanding; fetches complete as hits or same-cycle refills
//   MISS   | refill in flight; every non-Ready cycle is a stall
module ucsbece154b_perf_counters #(
  parameter int CNT_WIDTH      = 32,
  parameter bit SATURATE       = 1'b1,
  parameter bit ENABLE_CTRFLOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  ucsbece154b_perf_counters_if.slave bus
);

  localparam int NCNT      = 9;
  localparam int C_FETCH   = 0;
  localparam int C_HIT     = 1;
  localparam int C_MISS    = 2;
  localparam int C_STALL   = 3;
  localparam int C_BRANCH  = 4;
  localparam int C_BR_OK   = 5;
  localparam int C_JUMP    = 6;
  localparam int C_JMP_OK  = 7;
  localparam int C_CYCLE   = 8;

  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NCNT-1:0]      inc;
  logic [CNT_WIDTH-1:0] cnt_q [NCNT];
  logic [CNT_WIDTH-1:0] cnt_d [NCNT];
  logic [NCNT-1:0]      ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_val_q, cnt_val_d;

  // Fetch FSM next state and per-counter increment requests.
  // The FSM advances regardless of Clear/Freeze; those only gate counting.
  always_comb begin
    state_d = state_q;
    inc     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.ReadEnable_i && bus.MemReadRequest_i) begin
          if (bus.Ready_i) begin
            inc[C_FETCH] = 1'b1;
            inc[C_MISS]  = 1'b1;
          end else begin
            state_d      = S_MISS;
            inc[C_STALL] = 1'b1;
          end
        end else if (bus.ReadEnable_i && bus.Ready_i) begin
          inc[C_FETCH] = 1'b1;
          inc[C_HIT]   = 1'b1;
        end
      end
      S_MISS: begin
        // A flush (ReadEnable low) does not abort the refill.
        if (bus.Ready_i) begin
          state_d      = S_IDLE;
          inc[C_FETCH] = 1'b1;
          inc[C_MISS]  = 1'b1;
        end else begin
          inc[C_STALL] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ENABLE_CTRFLOW) begin
      inc[C_BRANCH] = bus.BranchE_i;
      inc[C_BR_OK]  = bus.BranchE_i && !bus.MispredictE_i;
      inc[C_JUMP]   = bus.JumpE_i;
      inc[C_JMP_OK] = bus.JumpE_i && !bus.MispredictE_i;
    end

    inc[C_CYCLE] = 1'b1;
  end

  // Counter bank update: Clear beats Freeze beats increment; overflow is sticky.
  always_comb begin
    for (int n = 0; n < NCNT; n++) begin
      cnt_d[n] = cnt_q[n];
      ovf_d[n] = ovf_q[n];
      if (bus.Clear_i) begin
        cnt_d[n] = '0;
        ovf_d[n] = 1'b0;
      end else if (!bus.Freeze_i && inc[n]) begin
        if (cnt_q[n] == ALL_ONES) begin
          ovf_d[n] = 1'b1;
          cnt_d[n] = SATURATE ? ALL_ONES : '0;
        end else begin
          cnt_d[n] = cnt_q[n] + ONE;
        end
      end
      // Control-flow counters tie off to constant zero when not built.
      if (!ENABLE_CTRFLOW && n >= C_BRANCH && n <= C_JMP_OK) begin
        cnt_d[n] = '0;
        ovf_d[n] = 1'b0;
      end
    end
  end

  // Readout mux; registered, so it shows the pre-increment value.
  always_comb begin
    cnt_val_d = '0;
    for (int n = 0; n < NCNT; n++) begin
      if (bus.CntSel_i == 4'(n)) cnt_val_d = cnt_q[n];
    end
  end

  // State, counters, overflow flags and readout register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ovf_q     <= '0;
      cnt_val_q <= '0;
      for (int n = 0; n < NCNT; n++) cnt_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      cnt_val_q <= cnt_val_d;
      for (int n = 0; n < NCNT; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  assign bus.CntValue_o = cnt_val_q;
  assign bus.Overflow_o = ovf_q;

endmodule

// File: tb/tb_ucsbece154b_perf_counters.sv
// Directed bench for ucsbece154b_perf_counters. Four instances share one
// stimulus stream: default (32b, saturate), 8b saturating, 8b wrapping,
// and 32b without control-flow counters.
module tb_ucsbece154b_perf_counters;

  logic clk;
  logic reset;
  logic re, rdy, mrr, br, jp, mp, clr, frz;
  logic [3:0] sel;

  int checks = 0;
  int passed = 0;

  logic [31:0] vm, vn;
  logic [7:0]  vs, vw;

  ucsbece154b_perf_counters_if #(.CNT_WIDTH(32)) if_main ();
  ucsbece154b_perf_counters_if #(.CNT_WIDTH(8))  if_sat ();
  ucsbece154b_perf_counters_if #(.CNT_WIDTH(8))  if_wrap ();
  ucsbece154b_perf_counters_if #(.CNT_WIDTH(32)) if_nocf ();

  assign if_main.ReadEnable_i = re, if_main.Ready_i = rdy, if_main.MemReadRequest_i = mrr,
         if_main.BranchE_i = br, if_main.JumpE_i = jp, if_main.MispredictE_i = mp,
         if_main.Clear_i = clr, if_main.Freeze_i = frz, if_main.CntSel_i = sel;
  assign if_sat.ReadEnable_i = re, if_sat.Ready_i = rdy, if_sat.MemReadRequest_i = mrr,
         if_sat.BranchE_i = br, if_sat.JumpE_i = jp, if_sat.MispredictE_i = mp,
         if_sat.Clear_i = clr, if_sat.Freeze_i = frz, if_sat.CntSel_i = sel;
  assign if_wrap.ReadEnable_i = re, if_wrap.Ready_i = rdy, if_wrap.MemReadRequest_i = mrr,
         if_wrap.BranchE_i = br, if_wrap.JumpE_i = jp, if_wrap.MispredictE_i = mp,
         if_wrap.Clear_i = clr, if_wrap.Freeze_i = frz, if_wrap.CntSel_i = sel;
  assign if_nocf.ReadEnable_i = re, if_nocf.Ready_i = rdy, if_nocf.MemReadRequest_i = mrr,
         if_nocf.BranchE_i = br, if_nocf.JumpE_i = jp, if_nocf.MispredictE_i = mp,
         if_nocf.Clear_i = clr, if_nocf.Freeze_i = frz, if_nocf.CntSel_i = sel;

  ucsbece154b_perf_counters #(.CNT_WIDTH(32), .SATURATE(1'b1), .ENABLE_CTRFLOW(1'b1))
    dut_main (.clk(clk), .reset(reset), .bus(if_main));
  ucsbece154b_perf_counters #(.CNT_WIDTH(8), .SATURATE(1'b1), .ENABLE_CTRFLOW(1'b1))
    dut_sat (.clk(clk), .reset(reset), .bus(if_sat));
  ucsbece154b_perf_counters #(.CNT_WIDTH(8), .SATURATE(1'b0), .ENABLE_CTRFLOW(1'b1))
    dut_wrap (.clk(clk), .reset(reset), .bus(if_wrap));
  ucsbece154b_perf_counters #(.CNT_WIDTH(32), .SATURATE(1'b1), .ENABLE_CTRFLOW(1'b0))
    dut_nocf (.clk(clk), .reset(reset), .bus(if_nocf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    re = 0; rdy = 0; mrr = 0; br = 0; jp = 0; mp = 0; clr = 0; frz = 0;
  endtask

  // One clock of stimulus, applied at the falling edge.
  task automatic drive(input logic r, input logic y, input logic m, input logic b,
                       input logic j, input logic p, input logic c, input logic f);
    @(negedge clk);
    re = r; rdy = y; mrr = m; br = b; jp = j; mp = p; clr = c; frz = f;
  endtask

  // Select a counter with idle inputs and sample the registered readout.
  task automatic read_cnt(input logic [3:0] s);
    @(negedge clk);
    set_idle();
    sel = s;
    @(negedge clk);
    vm = if_main.CntValue_o; vs = if_sat.CntValue_o;
    vw = if_wrap.CntValue_o; vn = if_nocf.CntValue_o;
  endtask

  task automatic test_reset();
    checks++; if (if_main.CntValue_o !== 32'd0) $display("FAIL reset_cntval: got %0d want 0", if_main.CntValue_o); else passed++;
    checks++; if (if_main.Overflow_o !== 9'd0) $display("FAIL reset_ovf: got %h want 000", if_main.Overflow_o); else passed++;
    checks++; if (if_sat.Overflow_o !== 9'd0) $display("FAIL reset_ovf_sat: got %h want 000", if_sat.Overflow_o); else passed++;
    read_cnt(4'd1);
    checks++; if (vm !== 32'd0) $display("FAIL reset_hit: got %0d want 0", vm); else passed++;
  endtask

  task automatic test_hits();
    sel = 4'd1;
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_idle();
    checks++; if (if_main.CntValue_o !== 32'd4) $display("FAIL hit_latency: got %0d want 4", if_main.CntValue_o); else passed++;
    read_cnt(4'd0);
    checks++; if (vm !== 32'd5) $display("FAIL hit_fetch: got %0d want 5", vm); else passed++;
    read_cnt(4'd1);
    checks++; if (vm !== 32'd5) $display("FAIL hit_hit: got %0d want 5", vm); else passed++;
    read_cnt(4'd2);
    checks++; if (vm !== 32'd0) $display("FAIL hit_miss: got %0d want 0", vm); else passed++;
    read_cnt(4'd3);
    checks++; if (vm !== 32'd0) $display("FAIL hit_stall: got %0d want 0", vm); else passed++;
    read_cnt(4'd9);
    checks++; if (vm !== 32'd0) $display("FAIL sel9: got %0d want 0", vm); else passed++;
    read_cnt(4'd15);
    checks++; if (vm !== 32'd0) $display("FAIL sel15: got %0d want 0", vm); else passed++;
  endtask

  task automatic test_miss();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    read_cnt(4'd3);
    checks++; if (vm !== 32'd4) $display("FAIL miss_stall: got %0d want 4", vm); else passed++;
    read_cnt(4'd2);
    checks++; if (vm !== 32'd1) $display("FAIL miss_miss: got %0d want 1", vm); else passed++;
    read_cnt(4'd0);
    checks++; if (vm !== 32'd1) $display("FAIL miss_fetch: got %0d want 1", vm); else passed++;
    read_cnt(4'd1);
    checks++; if (vm !== 32'd0) $display("FAIL miss_hit: got %0d want 0", vm); else passed++;
    // Back in IDLE: a plain ready fetch must be a hit.
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    read_cnt(4'd1);
    checks++; if (vm !== 32'd1) $display("FAIL miss_then_hit: got %0d want 1", vm); else passed++;
    read_cnt(4'd2);
    checks++; if (vm !== 32'd1) $display("FAIL miss_then_hit_miss: got %0d want 1", vm); else passed++;
    // Flush during miss, then a same-cycle refill.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    read_cnt(4'd2);
    checks++; if (vm !== 32'd2) $display("FAIL flush_miss: got %0d want 2", vm); else passed++;
    read_cnt(4'd3);
    checks++; if (vm !== 32'd3) $display("FAIL flush_stall: got %0d want 3", vm); else passed++;
    read_cnt(4'd0);
    checks++; if (vm !== 32'd2) $display("FAIL flush_fetch: got %0d want 2", vm); else passed++;
    read_cnt(4'd1);
    checks++; if (vm !== 32'd0) $display("FAIL flush_hit: got %0d want 0", vm); else passed++;
  endtask

  task automatic test_overflow();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
    read_cnt(4'd1);
    checks++; if (vs !== 8'd255) $display("FAIL sat_hit: got %0d want 255", vs); else passed++;
    checks++; if (vw !== 8'd44) $display("FAIL wrap_hit: got %0d want 44", vw); else passed++;
    checks++; if (vm !== 32'd300) $display("FAIL wide_hit: got %0d want 300", vm); else passed++;
    read_cnt(4'd0);
    checks++; if (vw !== 8'd44) $display("FAIL wrap_fetch: got %0d want 44", vw); else passed++;
    checks++; if (if_sat.Overflow_o[1] !== 1'b1) $display("FAIL sat_ovf1: got %b want 1", if_sat.Overflow_o[1]); else passed++;
    checks++; if (if_wrap.Overflow_o[1] !== 1'b1) $display("FAIL wrap_ovf1: got %b want 1", if_wrap.Overflow_o[1]); else passed++;
    checks++; if (if_sat.Overflow_o[2] !== 1'b0) $display("FAIL sat_ovf2: got %b want 0", if_sat.Overflow_o[2]); else passed++;
    checks++; if (if_main.Overflow_o !== 9'd0) $display("FAIL wide_ovf: got %h want 000", if_main.Overflow_o); else passed++;
  endtask

  task automatic test_ctrflow();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    // Ten branches; jumps ride on the first four. Mispredict on cycles 1, 5, 8.
    for (int i = 0; i < 10; i++)
      drive(0, 0, 0, 1, (i < 4), (i == 1 || i == 5 || i == 8), 0, 0);
    read_cnt(4'd4);
    checks++; if (vm !== 32'd10) $display("FAIL branch: got %0d want 10", vm); else passed++;
    checks++; if (vn !== 32'd0) $display("FAIL nocf_branch: got %0d want 0", vn); else passed++;
    read_cnt(4'd5);
    checks++; if (vm !== 32'd7) $display("FAIL branch_ok: got %0d want 7", vm); else passed++;
    checks++; if (vn !== 32'd0) $display("FAIL nocf_branch_ok: got %0d want 0", vn); else passed++;
    read_cnt(4'd6);
    checks++; if (vm !== 32'd4) $display("FAIL jump: got %0d want 4", vm); else passed++;
    checks++; if (vn !== 32'd0) $display("FAIL nocf_jump: got %0d want 0", vn); else passed++;
    read_cnt(4'd7);
    checks++; if (vm !== 32'd3) $display("FAIL jump_ok: got %0d want 3", vm); else passed++;
    checks++; if (vs !== 8'd3) $display("FAIL sat_jump_ok: got %0d want 3", vs); else passed++;
    checks++; if (vn !== 32'd0) $display("FAIL nocf_jump_ok: got %0d want 0", vn); else passed++;
  endtask

  task automatic test_clear();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 260; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (if_sat.Overflow_o[1] !== 1'b1) $display("FAIL preclear_ovf1: got %b want 1", if_sat.Overflow_o[1]); else passed++;
    // Clear coincides with a hit: the hit is lost.
    re = 1; rdy = 1; mrr = 0; clr = 1;
    @(negedge clk);
    set_idle();
    checks++; if (if_sat.Overflow_o !== 9'd0) $display("FAIL clear_ovf_sat: got %h want 000", if_sat.Overflow_o); else passed++;
    checks++; if (if_wrap.Overflow_o !== 9'd0) $display("FAIL clear_ovf_wrap: got %h want 000", if_wrap.Overflow_o); else passed++;
    read_cnt(4'd1);
    checks++; if (vm !== 32'd0) $display("FAIL clear_hit: got %0d want 0", vm); else passed++;
    checks++; if (vs !== 8'd0) $display("FAIL clear_hit_sat: got %0d want 0", vs); else passed++;
    read_cnt(4'd0);
    checks++; if (vm !== 32'd0) $display("FAIL clear_fetch: got %0d want 0", vm); else passed++;
  endtask

  task automatic test_freeze();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) drive(1, 1, 0, 1, 0, 0, 0, 1);
    read_cnt(4'd8);
    checks++; if (vm !== 32'd0) $display("FAIL freeze_cycle: got %0d want 0", vm); else passed++;
    read_cnt(4'd8);
    checks++; if (vm !== 32'd2) $display("FAIL unfreeze_cycle: got %0d want 2", vm); else passed++;
    read_cnt(4'd0);
    checks++; if (vm !== 32'd0) $display("FAIL freeze_fetch: got %0d want 0", vm); else passed++;
    read_cnt(4'd4);
    checks++; if (vm !== 32'd0) $display("FAIL freeze_branch: got %0d want 0", vm); else passed++;
    // Miss starts unfrozen, completes while frozen, then a hit.
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    read_cnt(4'd2);
    checks++; if (vm !== 32'd0) $display("FAIL frozen_miss: got %0d want 0", vm); else passed++;
    read_cnt(4'd3);
    checks++; if (vm !== 32'd1) $display("FAIL frozen_stall: got %0d want 1", vm); else passed++;
    read_cnt(4'd1);
    checks++; if (vm !== 32'd1) $display("FAIL post_freeze_hit: got %0d want 1", vm); else passed++;
    read_cnt(4'd0);
    checks++; if (vm !== 32'd1) $display("FAIL post_freeze_fetch: got %0d want 1", vm); else passed++;
  endtask

  task automatic test_async_reset();
    sel = 4'd3;
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (if_main.CntValue_o !== 32'd3) $display("FAIL inmiss_stall: got %0d want 3", if_main.CntValue_o); else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (if_main.CntValue_o !== 32'd0) $display("FAIL async_cntval: got %0d want 0", if_main.CntValue_o); else passed++;
    checks++; if (if_main.Overflow_o !== 9'd0) $display("FAIL async_ovf: got %h want 000", if_main.Overflow_o); else passed++;
    #1;
    reset = 1'b0;
    re = 1; rdy = 1; mrr = 0;
    @(negedge clk);
    set_idle();
    read_cnt(4'd1);
    checks++; if (vm !== 32'd1) $display("FAIL async_hit: got %0d want 1", vm); else passed++;
    read_cnt(4'd2);
    checks++; if (vm !== 32'd0) $display("FAIL async_miss: got %0d want 0", vm); else passed++;
    read_cnt(4'd3);
    checks++; if (vm !== 32'd0) $display("FAIL async_stall: got %0d want 0", vm); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_idle();
    sel = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_hits();
    test_miss();
    test_overflow();
    test_ctrflow();
    test_clear();
    test_freeze();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
